// File: rtl/isa_mem_target.sv
// ISA memory-window responder: turns MEMR/MEMW hits into single-beat req/ack backend requests.
// Define ISA_TGT_TIMEOUT_EN to abort a request when the backend ack takes longer than MAX_WAIT.
module isa_mem_target #(
    parameter logic [23:0] BASE_ADDR = 24'h0D0000,
    parameter int unsigned WIN_BITS  = 12,
    parameter int unsigned MAX_WAIT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [23:0]         isa_addr,
    input  logic                bale,
    input  logic                mem_r,
    input  logic                mem_w,
    input  logic [7:0]          isa_data_i,
    output logic [7:0]          isa_data_o,
    output logic                isa_data_oe,
    output logic                io_chrdy,
    output logic                bk_req,
    output logic                bk_we,
    output logic [WIN_BITS-1:0] bk_addr,
    output logic [7:0]          bk_wdata,
    input  logic [7:0]          bk_rdata,
    input  logic                bk_ack,
    output logic                err_timeout
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e state_q, state_d;

    logic mem_r_s1_q, mem_r_s2_q, mem_r_prev_q;
    logic mem_w_s1_q, mem_w_s2_q, mem_w_prev_q;

    logic [23:0] addr_q;

    logic [7:0]          data_o_q, data_o_d;
    logic                data_oe_q, data_oe_d;
    logic                chrdy_q, chrdy_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [WIN_BITS-1:0] bk_addr_q, bk_addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                err_q, err_d;

    logic hit;
    logic trig_rd, trig_wr;
    logic strobes_idle;

`ifdef ISA_TGT_TIMEOUT_EN
    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            wait_expired;

    assign wait_expired = (wait_cnt_q == CntW'(MAX_WAIT - 1));
`else
    logic [31:0] unused_max_wait;
    assign unused_max_wait = MAX_WAIT;
`endif

    // Strobes are asynchronous to clk; synchronizers idle high so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r_s1_q   <= 1'b1;
            mem_r_s2_q   <= 1'b1;
            mem_r_prev_q <= 1'b1;
            mem_w_s1_q   <= 1'b1;
            mem_w_s2_q   <= 1'b1;
            mem_w_prev_q <= 1'b1;
        end else begin
            mem_r_s1_q   <= mem_r;
            mem_r_s2_q   <= mem_r_s1_q;
            mem_r_prev_q <= mem_r_s2_q;
            mem_w_s1_q   <= mem_w;
            mem_w_s2_q   <= mem_w_s1_q;
            mem_w_prev_q <= mem_w_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else if (bale) begin
            addr_q <= isa_addr;
        end
    end

    assign hit          = (addr_q[23:WIN_BITS] == BASE_ADDR[23:WIN_BITS]);
    // A falling edge counts only while the other strobe is still high.
    assign trig_rd      = mem_r_prev_q & ~mem_r_s2_q & mem_w_s2_q;
    assign trig_wr      = mem_w_prev_q & ~mem_w_s2_q & mem_r_s2_q;
    assign strobes_idle = mem_r_s2_q & mem_w_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_o_d  = data_o_q;
        data_oe_d = data_oe_q;
        chrdy_d   = chrdy_q;
        req_d     = req_q;
        we_d      = we_q;
        bk_addr_d = bk_addr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
`ifdef ISA_TGT_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (hit && (trig_rd || trig_wr)) begin
                    bk_addr_d = addr_q[WIN_BITS-1:0];
                    we_d      = trig_wr;
                    if (trig_wr) begin
                        wdata_d = isa_data_i;
                    end
                    if (trig_rd) begin
                        data_oe_d = 1'b1;
                    end
                    req_d   = 1'b1;
                    chrdy_d = 1'b0;
`ifdef ISA_TGT_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bk_ack) begin
                    req_d   = 1'b0;
                    chrdy_d = 1'b1;
                    if (!we_q) begin
                        data_o_d = bk_rdata;
                    end
                    state_d = StDone;
                end
`ifdef ISA_TGT_TIMEOUT_EN
                else if (wait_expired) begin
                    req_d   = 1'b0;
                    chrdy_d = 1'b1;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        data_o_d = 8'hFF;
                    end
                    state_d = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
`endif
            end
            StDone: begin
                // An aborted master already has both strobes high, so this exits at once.
                if (strobes_idle) begin
                    data_oe_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o_q  <= 8'hFF;
            data_oe_q <= 1'b0;
            chrdy_q   <= 1'b1;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            bk_addr_q <= '0;
            wdata_q   <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            data_o_q  <= data_o_d;
            data_oe_q <= data_oe_d;
            chrdy_q   <= chrdy_d;
            req_q     <= req_d;
            we_q      <= we_d;
            bk_addr_q <= bk_addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

`ifdef ISA_TGT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign isa_data_o  = data_o_q;
    assign isa_data_oe = data_oe_q;
    assign io_chrdy    = chrdy_q;
    assign bk_req      = req_q;
    assign bk_we       = we_q;
    assign bk_addr     = bk_addr_q;
    assign bk_wdata    = wdata_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_isa_mem_target.sv
// Bench for isa_mem_target: directed test-plan cases plus randomized ISA cycles checked every
// cycle against a transaction-level model of the responder.
module tb_isa_mem_target;

    localparam logic [23:0] Base = 24'h0D0000;
    localparam int unsigned WinBits = 12;
    localparam int unsigned MaxWait = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] isa_addr;
    logic        bale;
    logic        mem_r;
    logic        mem_w;
    logic [7:0]  isa_data_i;
    logic [7:0]  isa_data_o;
    logic        isa_data_oe;
    logic        io_chrdy;
    logic        bk_req;
    logic        bk_we;
    logic [11:0] bk_addr;
    logic [7:0]  bk_wdata;
    logic [7:0]  bk_rdata;
    logic        bk_ack;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    isa_mem_target #(
        .BASE_ADDR (Base),
        .WIN_BITS  (WinBits),
        .MAX_WAIT  (MaxWait)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .isa_addr    (isa_addr),
        .bale        (bale),
        .mem_r       (mem_r),
        .mem_w       (mem_w),
        .isa_data_i  (isa_data_i),
        .isa_data_o  (isa_data_o),
        .isa_data_oe (isa_data_oe),
        .io_chrdy    (io_chrdy),
        .bk_req      (bk_req),
        .bk_we       (bk_we),
        .bk_addr     (bk_addr),
        .bk_wdata    (bk_wdata),
        .bk_rdata    (bk_rdata),
        .bk_ack      (bk_ack),
        .err_timeout (err_timeout)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs derived from the bus-level rules.
    logic        started = 1'b0;
    logic        e_chrdy, e_req, e_we, e_oe, e_err;
    logic [11:0] e_addr;
    logic [7:0]  e_wdata, e_data;
    int          m_phase;   // 0 waiting for a cycle, 1 backend busy, 2 holding result
    int          m_wait;
    logic [2:0]  hist_r, hist_w; // strobe samples from 1, 2 and 3 edges ago
    logic [23:0] m_addr;

    always @(posedge clk) begin : model
        logic r_seen, w_seen, r_fell, w_fell, in_win;
        e_err = 1'b0;
        if (rst) begin
            started = 1'b1;
            e_chrdy = 1'b1; e_req = 1'b0; e_we = 1'b0; e_oe = 1'b0;
            e_addr = '0; e_wdata = 8'h00; e_data = 8'hFF;
            m_phase = 0; m_wait = 0; m_addr = '0;
            hist_r = 3'b111; hist_w = 3'b111;
        end else begin
            // Strobes are seen two clocks late; a fall is the step between the last two views.
            r_seen = hist_r[1];
            w_seen = hist_w[1];
            r_fell = hist_r[2] && !hist_r[1];
            w_fell = hist_w[2] && !hist_w[1];
            in_win = (m_addr >> WinBits) == (Base >> WinBits);
            if (m_phase == 0) begin
                if (in_win && ((r_fell && w_seen) || (w_fell && r_seen))) begin
                    e_we = w_fell;
                    e_addr = m_addr[11:0];
                    if (w_fell) e_wdata = isa_data_i;
                    if (r_fell) e_oe = 1'b1;
                    e_req = 1'b1;
                    e_chrdy = 1'b0;
                    m_wait = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_wait++;
                if (bk_ack) begin
                    e_req = 1'b0; e_chrdy = 1'b1;
                    if (!e_we) e_data = bk_rdata;
                    m_phase = 2;
                end
`ifdef ISA_TGT_TIMEOUT_EN
                else if (m_wait == MaxWait) begin
                    e_req = 1'b0; e_chrdy = 1'b1; e_err = 1'b1;
                    if (!e_we) e_data = 8'hFF;
                    m_phase = 2;
                end
`endif
            end else begin
                if (r_seen && w_seen) begin
                    e_oe = 1'b0;
                    m_phase = 0;
                end
            end
            if (bale) m_addr = isa_addr;
            hist_r = {hist_r[1:0], mem_r};
            hist_w = {hist_w[1:0], mem_w};
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("io_chrdy", io_chrdy, e_chrdy);
            chk("bk_req", bk_req, e_req);
            chk("isa_data_oe", isa_data_oe, e_oe);
            chk("err_timeout", err_timeout, e_err);
            if (e_req) begin
                chk("bk_we", bk_we, e_we);
                chk("bk_addr", bk_addr, e_addr);
                if (e_we) chk("bk_wdata", bk_wdata, e_wdata);
            end
            if (e_oe) chk("isa_data_o", isa_data_o, e_data);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_addr(input logic [23:0] a);
        isa_addr = a;
        bale = 1'b1;
        cyc(1);
        bale = 1'b0;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            cyc(1);
            if (bk_req === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic ack(input logic [7:0] d);
        bk_rdata = d;
        bk_ack = 1'b1;
        cyc(1);
        bk_ack = 1'b0;
        bk_rdata = 8'($urandom);
    endtask

    task automatic wait_rdy(input int budget);
        int n;
        n = 0;
        while (io_chrdy !== 1'b1 && n < budget) begin
            cyc(1);
            n++;
        end
        chk("wait_io_chrdy", io_chrdy, 1'b1);
    endtask

    initial begin
        bit          seen, abort;
        int          op, dly, n;
        logic [23:0] a;
        logic [11:0] up;
        logic [7:0]  d;

        rst = 1'b1; isa_addr = '0; bale = 1'b0; mem_r = 1'b1; mem_w = 1'b1;
        isa_data_i = 8'h00; bk_rdata = 8'h00; bk_ack = 1'b0;
        cyc(3);
        chk("rst_chrdy", io_chrdy, 1'b1);
        chk("rst_oe", isa_data_oe, 1'b0);
        chk("rst_data", isa_data_o, 8'hFF);
        chk("rst_req", bk_req, 1'b0);
        chk("rst_we", bk_we, 1'b0);
        chk("rst_addr", bk_addr, 12'h000);
        chk("rst_wdata", bk_wdata, 8'h00);
        chk("rst_err", err_timeout, 1'b0);
        rst = 1'b0;
        cyc(3);

        // Read hit, ack after 5 cycles
        set_addr(24'h0D0123);
        mem_r = 1'b0;
        wait_req(seen);
        chk("rd_req_seen", seen, 1'b1);
        chk("rd_bk_addr", bk_addr, 12'h123);
        chk("rd_bk_we", bk_we, 1'b0);
        chk("rd_oe", isa_data_oe, 1'b1);
        cyc(4);
        chk("rd_wait", io_chrdy, 1'b0);
        ack(8'h5A);
        chk("rd_rdy_after_ack", io_chrdy, 1'b1);
        chk("rd_data", isa_data_o, 8'h5A);
        mem_r = 1'b1;
        cyc(1);
        chk("rd_oe_hold", isa_data_oe, 1'b1);
        cyc(4);
        chk("rd_oe_release", isa_data_oe, 1'b0);

        // Write hit, ack after 1 cycle
        set_addr(24'h0D0FFF);
        isa_data_i = 8'hC3;
        mem_w = 1'b0;
        wait_req(seen);
        isa_data_i = 8'h00;
        chk("wr_req_seen", seen, 1'b1);
        chk("wr_bk_we", bk_we, 1'b1);
        chk("wr_bk_addr", bk_addr, 12'hFFF);
        chk("wr_bk_wdata", bk_wdata, 8'hC3);
        chk("wr_oe", isa_data_oe, 1'b0);
        cyc(1);
        ack(8'h99);
        chk("wr_rdy", io_chrdy, 1'b1);
        mem_w = 1'b1;
        cyc(5);

        // Miss, then both strobes low, then a stray ack
        set_addr(24'h0E0000);
        mem_r = 1'b0;
        cyc(8);
        chk("miss_req", bk_req, 1'b0);
        chk("miss_chrdy", io_chrdy, 1'b1);
        chk("miss_oe", isa_data_oe, 1'b0);
        mem_r = 1'b1;
        cyc(5);
        set_addr(24'h0D0010);
        mem_r = 1'b0; mem_w = 1'b0;
        cyc(8);
        chk("both_req", bk_req, 1'b0);
        chk("both_chrdy", io_chrdy, 1'b1);
        mem_r = 1'b1; mem_w = 1'b1;
        cyc(5);
        ack(8'h77);
        chk("stray_req", bk_req, 1'b0);
        chk("stray_chrdy", io_chrdy, 1'b1);
        chk("stray_data", isa_data_o, 8'h5A);
        cyc(3);

        // Backend never acks
        set_addr(24'h0D0042);
        mem_r = 1'b0;
        wait_req(seen);
        chk("to_req_seen", seen, 1'b1);
`ifdef ISA_TGT_TIMEOUT_EN
        n = 0;
        while (io_chrdy !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("to_cycles", n, MaxWait);
        chk("to_err", err_timeout, 1'b1);
        chk("to_data", isa_data_o, 8'hFF);
        cyc(1);
        chk("to_err_pulse", err_timeout, 1'b0);
`else
        cyc(70);
        chk("noto_chrdy", io_chrdy, 1'b0);
        chk("noto_err", err_timeout, 1'b0);
        ack(8'h3C);
        chk("noto_rdy", io_chrdy, 1'b1);
`endif
        mem_r = 1'b1;
        cyc(5);

        // Reset while the backend is busy; a late ack must be ignored
        set_addr(24'h0D0200);
        mem_r = 1'b0;
        wait_req(seen);
        chk("rst_mid_req_seen", seen, 1'b1);
        rst = 1'b1;
        cyc(1);
        chk("rst_mid_chrdy", io_chrdy, 1'b1);
        chk("rst_mid_req", bk_req, 1'b0);
        chk("rst_mid_oe", isa_data_oe, 1'b0);
        mem_r = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        ack(8'h11);
        chk("late_ack_req", bk_req, 1'b0);
        chk("late_ack_chrdy", io_chrdy, 1'b1);
        chk("late_ack_data", isa_data_o, 8'hFF);
        cyc(3);

        // Randomized cycles against the model
        for (int t = 0; t < 80; t++) begin
            op = $urandom_range(0, 4);
            d = 8'($urandom);
            dly = $urandom_range(0, 8);
            a = 24'($urandom_range(0, 4095)) | Base;
            if (op == 2) begin
                do up = 12'($urandom); while (up == 12'h0D0);
                a = {up, 12'($urandom)};
            end
            if (op == 4) begin
                ack(d);
                cyc(2);
            end else begin
                set_addr(a);
                isa_addr = 24'($urandom);
                isa_data_i = d;
                if (op == 1) mem_w = 1'b0;
                else if (op == 3) begin mem_r = 1'b0; mem_w = 1'b0; end
                else mem_r = 1'b0;
                if (op <= 1) begin
                    wait_req(seen);
                    chk("rnd_req_seen", seen, 1'b1);
                    isa_data_i = 8'($urandom);
                    abort = ($urandom_range(0, 3) == 0);
                    if (abort) begin mem_r = 1'b1; mem_w = 1'b1; end
                    cyc(dly);
                    ack(8'($urandom));
                    wait_rdy(4);
                end else begin
                    cyc(8);
                end
                mem_r = 1'b1; mem_w = 1'b1;
                cyc(5);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
